rtu_rx_frame_ctrl: RTL and testbench

- Modbus RTU receive-frame sequencer between the UART byte receiver and the frame buffer / PDU parser.
- Measures silent time on the line in bit-times and applies the RTU 1.5T (inter-character) and 3.5T (inter-frame) rules.
- Writes accepted bytes into the frame buffer, then presents a completed frame to the parser with a valid/ack handshake.
- Rejects frames with gap violations, overflow, short length, or overrun, and reports the cause.

---
 rtl/rtu_rx_frame_ctrl.sv | 165 ++++++++++++++++
 tb/tb_rtu_rx_frame_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtu_rx_frame_ctrl.sv
// Modbus RTU receive-frame sequencer: times line silence in bit-times, writes
// accepted bytes to the frame buffer and hands complete frames to the parser.
module rtu_rx_frame_ctrl #(
   parameter int unsigned CLK_FREQ  = 50000000,
   parameter int unsigned BAUD_RATE = 9600,
   parameter int unsigned T15_BITS  = 15,
   parameter int unsigned T35_BITS  = 35,
   parameter int unsigned MIN_LEN   = 4,
   parameter int unsigned MAX_LEN   = 256
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       rx_done,
   input  logic [7:0] rx_data,
   input  logic       rx_state,
   output logic       fb_wr_en,
   output logic [7:0] fb_wr_addr,
   output logic [7:0] fb_wr_data,
   output logic       frame_valid,
   output logic [8:0] frame_len,
   input  logic       frame_ack,
   output logic       frame_err,
   output logic [1:0] err_code
);

   localparam int unsigned BPS_PARAM = CLK_FREQ / BAUD_RATE;
   localparam int unsigned DIV_W     = (BPS_PARAM > 1) ? $clog2(BPS_PARAM) : 1;
   localparam int unsigned GAP_W     = $clog2(T35_BITS + 1);
   localparam int unsigned CNT_W     = 9;

   localparam logic [1:0] ERR_GAP   = 2'b01;
   localparam logic [1:0] ERR_OVF   = 2'b10;
   localparam logic [1:0] ERR_SHORT = 2'b11;

   typedef enum logic [2:0] {
      S_INIT,
      S_IDLE,
      S_RECV,
      S_GAP,
      S_DISCARD,
      S_DONE
   } state_t;

   state_t             state;
   logic [DIV_W-1:0]   div_cnt;
   logic [GAP_W-1:0]   gap_bits;
   logic [CNT_W-1:0]   cnt;
   logic [1:0]         err_lat;
   logic               ovr;
   logic               t15;
   logic               t35;

   assign t15 = (gap_bits >= GAP_W'(T15_BITS));
   assign t35 = (gap_bits >= GAP_W'(T35_BITS));

   // Silence timer: bit-time divider feeding a saturating bit-time counter
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         div_cnt  <= '0;
         gap_bits <= '0;
      end else if (rx_done || rx_state) begin
         div_cnt  <= '0;
         gap_bits <= '0;
      end else if (div_cnt == DIV_W'(BPS_PARAM - 1)) begin
         div_cnt <= '0;
         if (gap_bits != GAP_W'(T35_BITS)) begin
            gap_bits <= gap_bits + GAP_W'(1);
         end
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   // Frame sequencer; a byte arrival always outranks a same-cycle silence threshold
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state       <= S_INIT;
         cnt         <= '0;
         err_lat     <= 2'b00;
         ovr         <= 1'b0;
         fb_wr_en    <= 1'b0;
         fb_wr_addr  <= 8'd0;
         fb_wr_data  <= 8'd0;
         frame_valid <= 1'b0;
         frame_len   <= 9'd0;
         frame_err   <= 1'b0;
         err_code    <= 2'b00;
      end else begin
         fb_wr_en  <= 1'b0;
         frame_err <= 1'b0;
         err_code  <= 2'b00;
         case (state)
            S_INIT: begin
               if (!rx_done && t35) begin
                  state <= S_IDLE;
               end
            end
            S_IDLE: begin
               if (rx_done) begin
                  fb_wr_en   <= 1'b1;
                  fb_wr_addr <= 8'd0;
                  fb_wr_data <= rx_data;
                  cnt        <= CNT_W'(1);
                  state      <= S_RECV;
               end
            end
            S_RECV: begin
               if (rx_done) begin
                  if (cnt < CNT_W'(MAX_LEN)) begin
                     fb_wr_en   <= 1'b1;
                     fb_wr_addr <= cnt[7:0];
                     fb_wr_data <= rx_data;
                     cnt        <= cnt + CNT_W'(1);
                  end else begin
                     err_lat <= ERR_OVF;
                     state   <= S_DISCARD;
                  end
               end else if (t15) begin
                  state <= S_GAP;
               end
            end
            S_GAP: begin
               if (rx_done) begin
                  err_lat <= ERR_GAP;
                  state   <= S_DISCARD;
               end else if (t35) begin
                  if (cnt < CNT_W'(MIN_LEN)) begin
                     frame_err <= 1'b1;
                     err_code  <= ERR_SHORT;
                     state     <= S_IDLE;
                  end else begin
                     frame_valid <= 1'b1;
                     frame_len   <= cnt;
                     ovr         <= 1'b0;
                     state       <= S_DONE;
                  end
               end
            end
            S_DISCARD: begin
               if (!rx_done && t35) begin
                  frame_err <= 1'b1;
                  err_code  <= err_lat;
                  state     <= S_IDLE;
               end
            end
            S_DONE: begin
               if (frame_ack) begin
                  frame_valid <= 1'b0;
                  ovr         <= 1'b0;
                  if (ovr || rx_done) begin
                     err_lat <= ERR_OVF;
                     state   <= S_DISCARD;
                  end else begin
                     state <= S_IDLE;
                  end
               end else if (rx_done) begin
                  ovr <= 1'b1;
               end
            end
            default: state <= S_INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_rtu_rx_frame_ctrl.sv
// Directed bench for rtu_rx_frame_ctrl: a silence-time frame model checked every
// cycle, plus literal expectations for each directed scenario.
module tb_rtu_rx_frame_ctrl;

   localparam int BPS  = 8;
   localparam int T15  = 15;
   localparam int T35  = 35;
   localparam int MINL = 4;
   localparam int MAXL = 256;

   localparam int M_INIT = 0, M_IDLE = 1, M_RECV = 2, M_GAP = 3, M_DISC = 4, M_DONE = 5;

   logic       clk_in = 1'b0;
   logic       rst_in = 1'b1;
   logic       rx_done = 1'b0;
   logic [7:0] rx_data = 8'd0;
   logic       rx_state = 1'b0;
   logic       frame_ack = 1'b0;
   logic       fb_wr_en;
   logic [7:0] fb_wr_addr;
   logic [7:0] fb_wr_data;
   logic       frame_valid;
   logic [8:0] frame_len;
   logic       frame_err;
   logic [1:0] err_code;

   int checks = 0;
   int passes = 0;

   rtu_rx_frame_ctrl #(
      .CLK_FREQ (BPS), .BAUD_RATE(1), .T15_BITS(T15), .T35_BITS(T35),
      .MIN_LEN  (MINL), .MAX_LEN(MAXL)
   ) dut (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .rx_done    (rx_done),
      .rx_data    (rx_data),
      .rx_state   (rx_state),
      .fb_wr_en   (fb_wr_en),
      .fb_wr_addr (fb_wr_addr),
      .fb_wr_data (fb_wr_data),
      .frame_valid(frame_valid),
      .frame_len  (frame_len),
      .frame_ack  (frame_ack),
      .frame_err  (frame_err),
      .err_code   (err_code)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Reference model: silence measured as raw idle cycles, frame held as a byte queue
   int       silence = 0;
   int       mode = M_INIT;
   int       frame_q[$];
   int       m_code = 0;
   bit       m_ovr = 1'b0;
   int       m_wr_en = 0, m_wr_addr = 0, m_wr_data = 0;
   int       m_valid = 0, m_len = 0, m_err = 0, m_err_code = 0;

   task automatic model_step();
      int g;
      if (rst_in) begin
         silence = 0; mode = M_INIT; frame_q.delete(); m_code = 0; m_ovr = 1'b0;
         m_wr_en = 0; m_wr_addr = 0; m_wr_data = 0;
         m_valid = 0; m_len = 0; m_err = 0; m_err_code = 0;
         return;
      end
      g = silence / BPS;
      if (g > T35) g = T35;
      m_wr_en = 0; m_err = 0; m_err_code = 0;
      case (mode)
         M_INIT: if (!rx_done && g >= T35) mode = M_IDLE;
         M_IDLE: if (rx_done) begin
            frame_q.delete();
            m_wr_en = 1; m_wr_addr = 0; m_wr_data = int'(rx_data);
            frame_q.push_back(int'(rx_data));
            mode = M_RECV;
         end
         M_RECV: begin
            if (rx_done) begin
               if (frame_q.size() < MAXL) begin
                  m_wr_en = 1; m_wr_addr = frame_q.size(); m_wr_data = int'(rx_data);
                  frame_q.push_back(int'(rx_data));
               end else begin
                  m_code = 2; mode = M_DISC;
               end
            end else if (g >= T15) mode = M_GAP;
         end
         M_GAP: begin
            if (rx_done) begin
               m_code = 1; mode = M_DISC;
            end else if (g >= T35) begin
               if (frame_q.size() < MINL) begin
                  m_err = 1; m_err_code = 3; mode = M_IDLE;
               end else begin
                  m_valid = 1; m_len = frame_q.size(); m_ovr = 1'b0; mode = M_DONE;
               end
            end
         end
         M_DISC: if (!rx_done && g >= T35) begin
            m_err = 1; m_err_code = m_code; mode = M_IDLE;
         end
         M_DONE: begin
            if (rx_done) m_ovr = 1'b1;
            if (frame_ack) begin
               m_valid = 0;
               if (m_ovr) begin m_code = 2; mode = M_DISC; end
               else mode = M_IDLE;
               m_ovr = 1'b0;
            end
         end
         default: mode = M_INIT;
      endcase
      if (rx_done || rx_state) silence = 0;
      else if (silence < (T35 + 1) * BPS) silence++;
   endtask

   initial forever begin
      @(posedge clk_in or posedge rst_in);
      model_step();
   end

   // Per-cycle compare plus an event log used by the scenario checks
   int wr_cnt = 0, err_cnt = 0, last_code = 0, valid_cnt = 0, last_len = 0;
   int wr_mem[MAXL];
   bit prev_valid = 1'b0;

   initial forever begin
      @(negedge clk_in);
      chk("wr_en", int'(fb_wr_en), m_wr_en);
      if (m_wr_en != 0) begin
         chk("wr_addr", int'(fb_wr_addr), m_wr_addr);
         chk("wr_data", int'(fb_wr_data), m_wr_data);
      end
      chk("frame_valid", int'(frame_valid), m_valid);
      if (m_valid != 0) chk("frame_len", int'(frame_len), m_len);
      chk("frame_err", int'(frame_err), m_err);
      if (m_err != 0) chk("err_code", int'(err_code), m_err_code);
      if (fb_wr_en) begin
         wr_cnt++;
         wr_mem[int'(fb_wr_addr)] = int'(fb_wr_data);
      end
      if (frame_err) begin
         err_cnt++;
         last_code = int'(err_code);
      end
      if (frame_valid && !prev_valid) begin
         valid_cnt++;
         last_len = int'(frame_len);
      end
      prev_valid = frame_valid;
   end

   task automatic step();
      @(negedge clk_in);
      #1;
   endtask

   task automatic send_byte(input int b);
      rx_state = 1'b1;
      step(); step();
      rx_state = 1'b0; rx_done = 1'b1; rx_data = 8'(b);
      step();
      rx_done = 1'b0;
   endtask

   task automatic idle_bits(input int bits);
      repeat (bits * BPS) step();
   endtask

   task automatic pulse_ack();
      frame_ack = 1'b1;
      step();
      frame_ack = 1'b0;
   endtask

   task automatic pulse_reset();
      rst_in = 1'b1;
      step(); step();
      rst_in = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0, e0, v0;
      step(); step();
      chk("reset wr_en", int'(fb_wr_en), 0);
      chk("reset valid", int'(frame_valid), 0);
      chk("reset err", int'(frame_err), 0);
      rst_in = 1'b0;

      // Back-to-back 8-byte frame after initial 3.5T silence
      idle_bits(36);
      w0 = wr_cnt; v0 = valid_cnt;
      for (int i = 1; i <= 8; i++) send_byte(i);
      idle_bits(36);
      chk("s1 writes", wr_cnt - w0, 8);
      for (int i = 0; i < 8; i++) chk("s1 data", wr_mem[i], i + 1);
      chk("s1 valid seen", valid_cnt - v0, 1);
      chk("s1 len", last_len, 8);
      chk("s1 valid held", int'(frame_valid), 1);
      pulse_ack();
      chk("s1 valid drop", int'(frame_valid), 0);

      // Byte during mandatory initial silence is ignored
      pulse_reset();
      w0 = wr_cnt; v0 = valid_cnt;
      idle_bits(20);
      send_byte(8'h55);
      idle_bits(5);
      chk("s2 ignored", wr_cnt - w0, 0);
      idle_bits(31);
      for (int i = 0; i < 4; i++) send_byte(8'hA0 + i);
      idle_bits(36);
      chk("s2 writes", wr_cnt - w0, 4);
      chk("s2 first byte", wr_mem[0], 8'hA0);
      chk("s2 len", last_len, 4);
      pulse_ack();

      // Inter-character gap violation
      w0 = wr_cnt; e0 = err_cnt; v0 = valid_cnt;
      for (int i = 0; i < 5; i++) send_byte(8'h10 + i);
      idle_bits(20);
      send_byte(8'h77);
      idle_bits(36);
      chk("s3 writes", wr_cnt - w0, 5);
      chk("s3 err", err_cnt - e0, 1);
      chk("s3 code", last_code, 1);
      chk("s3 no valid", valid_cnt - v0, 0);

      // Short frame
      w0 = wr_cnt; e0 = err_cnt;
      for (int i = 0; i < 3; i++) send_byte(8'h20 + i);
      idle_bits(36);
      chk("s4 writes", wr_cnt - w0, 3);
      chk("s4 err", err_cnt - e0, 1);
      chk("s4 code", last_code, 3);

      // 257-byte overflow
      w0 = wr_cnt; e0 = err_cnt; v0 = valid_cnt;
      for (int i = 0; i < 257; i++) send_byte(i & 255);
      idle_bits(36);
      chk("s4 ovf writes", wr_cnt - w0, 256);
      chk("s4 ovf last data", wr_mem[255], 8'hFF);
      chk("s4 ovf err", err_cnt - e0, 1);
      chk("s4 ovf code", last_code, 2);
      chk("s4 ovf no valid", valid_cnt - v0, 0);

      // Overrun while a presented frame waits for ack
      w0 = wr_cnt; e0 = err_cnt;
      for (int i = 0; i < 6; i++) send_byte(8'h30 + i);
      idle_bits(36);
      chk("s5 len", last_len, 6);
      send_byte(8'hE1);
      send_byte(8'hE2);
      idle_bits(10);
      chk("s5 valid before ack", int'(frame_valid), 1);
      chk("s5 len held", int'(frame_len), 6);
      pulse_ack();
      chk("s5 valid drop", int'(frame_valid), 0);
      chk("s5 no early err", err_cnt - e0, 0);
      idle_bits(27);
      chk("s5 writes", wr_cnt - w0, 6);
      chk("s5 err", err_cnt - e0, 1);
      chk("s5 code", last_code, 2);

      // Reset mid-frame
      e0 = err_cnt;
      for (int i = 0; i < 3; i++) send_byte(8'h40 + i);
      rst_in = 1'b1;
      #1;
      chk("s6 rst addr", int'(fb_wr_addr), 0);
      chk("s6 rst data", int'(fb_wr_data), 0);
      chk("s6 rst len", int'(frame_len), 0);
      step();
      rst_in = 1'b0;
      idle_bits(36);
      w0 = wr_cnt;
      for (int i = 0; i < 4; i++) send_byte(8'h50 + i);
      idle_bits(36);
      chk("s6 writes", wr_cnt - w0, 4);
      chk("s6 len", last_len, 4);
      chk("s6 no err", err_cnt - e0, 0);
      pulse_ack();
      step();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
